fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent in WAIT without imem_ack before FAULT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 load_ir  input  1  control unit request to fetch instruction at pc into ir.
REQ-006 load_pc  input  1  control unit request to advance pc to next_pc.
REQ-007 pc_next_sel  input  1  0: next_pc = pc + 4; 1: next_pc = branch target.
REQ-008 pc_adder_sel  input  1  branch base: 0: pc; 1: rs1_val.
REQ-009 imm  input  32  sign-extended immediate from decode.
REQ-010 rs1_val  input  32  register-file read port 1 value.
REQ-011 imem_req  output  1  instruction memory read request.
REQ-012 imem_addr  output  32  instruction memory byte address.
REQ-013 imem_rdata  input  32  instruction memory read data, valid when imem_ack = 1.
REQ-014 imem_ack  input  1  instruction memory completion strobe.
REQ-015 pc  output  32  current program counter.
REQ-016 ir  output  32  instruction register.
REQ-017 opcode  output  7  ir[6:0], consumed by the control unit FSM.
REQ-018 fetch_busy  output  1  1 while a fetch is outstanding; control unit stalls on it.
REQ-019 ir_valid  output  1  1 once ir holds a completed fetch.
REQ-020 misalign_err  output  1  sticky: a load_pc produced next_pc[1:0] != 0.
REQ-021 fault  output  1  fetch timeout; sticky until reset.

Function
REQ-022 FSM states IDLE, WAIT, FAULT; no other reachable state.
REQ-023 IDLE: load_ir = 1 -> WAIT next edge; ir_valid cleared at that edge.
REQ-024 WAIT: imem_req = 1, imem_addr = pc, both stable throughout WAIT; imem_req = 0 in IDLE and FAULT.
REQ-025 WAIT with imem_ack = 1: ir <= imem_rdata, ir_valid <= 1, -> IDLE at same edge; minimum fetch latency 1 cycle after load_ir.
REQ-026 WAIT counter starts at 0 on entry, increments each WAIT cycle without ack; reaching TIMEOUT-1 without ack -> FAULT; ack on the final cycle wins over timeout.
REQ-027 FAULT: terminal until reset; fault = 1, fetch_busy = 0, load_ir/load_pc ignored.
REQ-028 fetch_busy = 1 exactly when state = WAIT.
REQ-029 load_ir in WAIT ignored; load_ir held high in IDLE starts a new fetch each IDLE cycle.
REQ-030 next_pc = pc_next_sel ? ((pc_adder_sel ? rs1_val : pc) + imm) : pc + 4; 32-bit, modulo 2^32 wrap, carry discarded.
REQ-031 load_pc in IDLE: pc <= next_pc at that edge.
REQ-032 load_pc in WAIT: next_pc captured in pending register, pending flag set; pc updated at the edge where WAIT exits on ack; second load_pc in WAIT overwrites pending value.
REQ-033 next_pc[1:0] != 0 on load_pc: pc unchanged, misalign_err <= 1 (sticky), no pending set.
REQ-034 load_ir and load_pc same IDLE cycle: fetch uses old pc; pc update deferred per REQ-032.
REQ-035 opcode = ir[6:0] combinationally.

Reset
REQ-036 reset = 0 asynchronously: state IDLE, pc = RESET_PC, ir = 0, ir_valid = 0, pending = 0, counter = 0, misalign_err = 0, fault = 0, imem_req = 0.
REQ-037 reset mid-WAIT aborts the fetch; late imem_ack after release ignored (IDLE).

Structure
REQ-038 Shared package holds state encoding, RESET_PC and TIMEOUT defaults, OP_IMM = 7'b0010011, OP = 7'b0110011.
REQ-039 One combinational sub-module pc_next_calc computes next_pc and misalignment flag.

Verification
REQ-040 Reset, load_ir=1, ack on 3rd WAIT cycle with rdata 32'h00500093 -> ir = 32'h00500093, opcode = 7'b0010011, fetch_busy high 3 cycles.
REQ-041 pc=32'h10, load_pc, pc_next_sel=0 -> pc=32'h14; pc_next_sel=1, pc_adder_sel=1, rs1_val=32'h100, imm=32'hFFFFFFF8 -> pc=32'hF8.
REQ-042 load_pc during WAIT -> pc unchanged and imem_addr stable until ack, pc updated at ack edge.
REQ-043 pc=32'hFFFFFFFC, load_pc, pc_next_sel=0 -> pc=32'h0; imm=32'h2, pc_next_sel=1 -> misalign_err=1, pc unchanged.
REQ-044 No ack for TIMEOUT=16 cycles -> fault=1, imem_req=0; further load_ir ignored until reset.
REQ-045 reset asserted during WAIT -> all outputs at REQ-036 values immediately, without clock edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// parameter defaults, opcode constants and the next-PC result payload.
package fetch_unit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            misalign;
    } next_pc_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read channel.
//   master (fetch unit): drives imem_req/imem_addr, receives imem_rdata/imem_ack
//   slave  (memory)    : the reverse
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC computation.
//   inputs : pc, rs1_val, imm, pc_next_sel, pc_adder_sel
//   output : next_pc_c (target address + low-bit misalignment flag)
module fetch_unit_pc_next_calc
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] imm,
    input  logic            pc_next_sel,
    input  logic            pc_adder_sel,
    output next_pc_t        next_pc_c
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;

    // 32-bit adds wrap naturally; carry out is dropped.
    always_comb begin
        base   = pc_adder_sel ? rs1_val : pc;
        target = pc_next_sel ? (base + imm) : (pc + XLEN'(4));
        next_pc_c.addr     = target;
        next_pc_c.misalign = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds pc/ir, issues one instruction memory read
// per load_ir, defers pc updates requested mid-fetch, and faults terminally
// when memory fails to acknowledge within TIMEOUT cycles.
//   clk, reset (async, active-low)
//   load_ir, load_pc, pc_next_sel, pc_adder_sel, imm, rs1_val : control/decode
//   imem (fetch_unit_if.master)                                : memory channel
//   pc, ir, opcode, fetch_busy, ir_valid, misalign_err, fault  : status
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_ir,
    input  logic            load_pc,
    input  logic            pc_next_sel,
    input  logic            pc_adder_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ir,
    output logic [6:0]      opcode,
    output logic            fetch_busy,
    output logic            ir_valid,
    output logic            misalign_err,
    output logic            fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e          state;
    state_e          state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic            pend;
    logic [XLEN-1:0] pend_pc;
    logic            req_d;
    logic            busy_d;
    logic            fault_d;
    logic            pc_ok;
    next_pc_t        npc;

    fetch_unit_pc_next_calc pc_next_calc (
        .pc           (pc),
        .rs1_val      (rs1_val),
        .imm          (imm),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .next_pc_c    (npc)
    );

    assign pc_ok          = load_pc && !npc.misalign;
    assign opcode         = ir[6:0];
    // pc never changes while WAIT is active, so the address is stable for the whole fetch.
    assign imem.imem_addr = pc;

    // Next-state logic; ack in the last counted cycle beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load_ir) state_next = ST_WAIT;
            ST_WAIT: begin
                if (imem.imem_ack)          state_next = ST_IDLE;
                else if (wait_cnt == CNT_LAST) state_next = ST_FAULT;
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the status outputs are flops.
    always_comb begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        case (state_next)
            ST_WAIT: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
            end
            ST_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    // State register plus datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            imem.imem_req <= 1'b0;
            fetch_busy    <= 1'b0;
            fault         <= 1'b0;
            wait_cnt      <= '0;
            pc            <= RESET_PC;
            ir            <= '0;
            ir_valid      <= 1'b0;
            pend          <= 1'b0;
            pend_pc       <= '0;
            misalign_err  <= 1'b0;
        end else begin
            state         <= state_next;
            imem.imem_req <= req_d;
            fetch_busy    <= busy_d;
            fault         <= fault_d;

            if (state == ST_WAIT && state_next == ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            else                                           wait_cnt <= '0;

            case (state)
                ST_IDLE: begin
                    if (load_ir) begin
                        ir_valid <= 1'b0;
                        // Fetch uses the current pc; the pc request waits for the ack.
                        if (pc_ok) begin
                            pend    <= 1'b1;
                            pend_pc <= npc.addr;
                        end
                    end else if (pc_ok) begin
                        pc <= npc.addr;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_ack) begin
                        ir       <= imem.imem_rdata;
                        ir_valid <= 1'b1;
                        pend     <= 1'b0;
                        // A request in the exit cycle is the newest and wins over the pending one.
                        if (pc_ok)     pc <= npc.addr;
                        else if (pend) pc <= pend_pc;
                    end else if (state_next == ST_FAULT) begin
                        pend <= 1'b0;
                    end else if (pc_ok) begin
                        pend    <= 1'b1;
                        pend_pc <= npc.addr;
                    end
                end
                default: ;
            endcase

            if (load_pc && npc.misalign && state != ST_FAULT) misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_ir, load_pc, pc_next_sel, pc_adder_sel;
    logic [31:0] imm, rs1_val;
    logic [31:0] pc, ir;
    logic [6:0]  opcode;
    logic        fetch_busy, ir_valid, misalign_err, fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .imem         (imem_bus),
        .pc           (pc),
        .ir           (ir),
        .opcode       (opcode),
        .fetch_busy   (fetch_busy),
        .ir_valid     (ir_valid),
        .misalign_err (misalign_err),
        .fault        (fault)
    );

    // Reference model: mode 0 idle, 1 fetching, 2 dead.
    int          m_mode;
    int          m_waited;
    logic [31:0] m_pc, m_ir;
    logic        m_irv, m_mis;
    logic [31:0] m_pend[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        m_mode   = 0;
        m_waited = 0;
        m_pc     = 32'h0;
        m_ir     = 32'h0;
        m_irv    = 1'b0;
        m_mis    = 1'b0;
        m_pend.delete();
    endfunction

    function automatic void mdl_step(input logic li, lp, ns, as, input logic [31:0] im, r1,
                                     input logic ak, input logic [31:0] rd);
        logic [31:0] tgt;
        logic        bad;
        tgt = ns ? ((as ? r1 : m_pc) + im) : (m_pc + 32'd4);
        bad = (tgt % 4) != 0;
        if (m_mode == 0) begin
            if (lp && bad) m_mis = 1'b1;
            if (li) begin
                if (lp && !bad) begin m_pend.delete(); m_pend.push_back(tgt); end
                m_mode = 1; m_waited = 0; m_irv = 1'b0;
            end else if (lp && !bad) begin
                m_pc = tgt;
            end
        end else if (m_mode == 1) begin
            if (lp && bad) m_mis = 1'b1;
            if (ak) begin
                m_ir = rd; m_irv = 1'b1; m_mode = 0;
                if (lp && !bad)         m_pc = tgt;
                else if (m_pend.size() > 0) m_pc = m_pend[0];
                m_pend.delete();
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_mode = 2; m_pend.delete();
                end else if (lp && !bad) begin
                    m_pend.delete(); m_pend.push_back(tgt);
                end
            end
        end
    endfunction

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("opcode", 32'(opcode), 32'(m_ir[6:0]));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_mode == 1));
        chk("imem_req", 32'(imem_bus.imem_req), 32'(m_mode == 1));
        if (m_mode == 1) chk("imem_addr", imem_bus.imem_addr, m_pc);
        chk("ir_valid", 32'(ir_valid), 32'(m_irv));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        chk("fault", 32'(fault), 32'(m_mode == 2));
    endtask

    task automatic step(input logic li, lp, ns, as, input logic [31:0] im, r1,
                        input logic ak, input logic [31:0] rd);
        load_ir = li; load_pc = lp; pc_next_sel = ns; pc_adder_sel = as;
        imm = im; rs1_val = r1;
        imem_bus.imem_ack = ak; imem_bus.imem_rdata = rd;
        mdl_step(li, lp, ns, as, im, r1, ak, rd);
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load_ir = 0; load_pc = 0; pc_next_sel = 0; pc_adder_sel = 0;
        imm = 0; rs1_val = 0; imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
        mdl_reset();
        #1 check_all();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        logic [31:0] r_imm, r_rs1;
        logic r_ack;

        @(posedge clk); #1;
        do_reset();

        // Fetch with ack on the third WAIT cycle.
        busy_cycles = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);              busy_cycles += int'(fetch_busy);
        step(0, 0, 0, 0, 0, 0, 0, 0);              busy_cycles += int'(fetch_busy);
        step(0, 0, 0, 0, 0, 0, 0, 0);              busy_cycles += int'(fetch_busy);
        step(0, 0, 0, 0, 0, 0, 1, 32'h00500093);   busy_cycles += int'(fetch_busy);
        chk("ir_addi", ir, 32'h00500093);
        chk("opcode_addi", 32'(opcode), 32'(OP_IMM));
        chk("busy_cycles", 32'(busy_cycles), 32'd3);

        // pc+4 and rs1-relative branch.
        step(0, 1, 1, 1, 32'h0, 32'h10, 0, 0);
        chk("pc_set10", pc, 32'h10);
        step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("pc_plus4", pc, 32'h14);
        step(0, 1, 1, 1, 32'hFFFF_FFF8, 32'h100, 0, 0);
        chk("pc_branch", pc, 32'hF8);

        // load_pc during WAIT is deferred to the ack edge.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("pc_hold_wait", pc, 32'hF8);
        chk("addr_hold_wait", imem_bus.imem_addr, 32'hF8);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_hold_wait2", imem_bus.imem_addr, 32'hF8);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0033);
        chk("pc_at_ack", pc, 32'hFC);

        // Wrap-around and misalignment.
        step(0, 1, 1, 1, 32'h0, 32'hFFFF_FFFC, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("pc_wrap", pc, 32'h0);
        step(0, 1, 1, 0, 32'h2, 0, 0, 0);
        chk("misalign_set", 32'(misalign_err), 32'd1);
        chk("misalign_pc", pc, 32'h0);

        // Timeout into terminal FAULT.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(TO); i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_req", 32'(imem_bus.imem_req), 32'd0);
        step(1, 1, 0, 0, 0, 0, 1, 32'h1234_5678);
        chk("fault_ignore", 32'(fetch_busy), 32'd0);

        // Asynchronous reset during WAIT, then a late ack.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        #3 reset = 1'b0;
        mdl_reset();
        #1 check_all();
        chk("async_busy", 32'(fetch_busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("late_ack_ir", ir, 32'h0);

        // Random traffic with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                r_imm = $urandom;
                r_rs1 = $urandom;
                if ($urandom_range(0, 7) != 0) r_imm[1:0] = 2'b00;
                if ($urandom_range(0, 7) != 0) r_rs1[1:0] = 2'b00;
                r_ack = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     r_imm, r_rs1, r_ack, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
